io_controller: RTL and testbench
================================

IO_CONTROLLER -- requirements
Module: io_controller

Interface
REQ-001 SHALL have parameter: IN_WIDTH, 16, width of external input-device data (switches).
REQ-002 SHALL have parameter: TIMEOUT_CYCLES, 1024, wait-state cycle limit (used only when IO_TIMEOUT_EN is defined).
REQ-003 SHALL have port: clk  input  1  single clock, rising-edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: inctrl  input  1  decoded "in" instruction request from the control unit (level).
REQ-006 SHALL have port: outctrl  input  1  decoded "out" instruction request from the control unit (level).
REQ-007 SHALL have port: rs_data  input  32  register value to be output.
REQ-008 SHALL have port: in_valid  input  1  input device has data.
REQ-009 SHALL have port: in_data  input  IN_WIDTH  input device data.
REQ-010 SHALL have port: in_req  output  1  request to input device.
REQ-011 SHALL have port: out_valid  output  1  output word valid to display device.
REQ-012 SHALL have port: out_word  output  32  latched output word.
REQ-013 SHALL have port: out_ack  input  1  display device accepted out_word.
REQ-014 SHALL have port: rd_data  output  32  input word for the register file.
REQ-015 SHALL have port: rd_we  output  1  register-file write strobe for rd_data.
REQ-016 SHALL have port: io_done  output  1  one-cycle pulse releasing the frozen PC (datapath ORs it with pcctrl).
REQ-017 SHALL have port: io_busy  output  1  transfer in progress.
REQ-018 SHALL have port: io_err  output  1  sticky timeout flag.

Function
REQ-019 SHALL implement FSM states IDLE, IN_WAIT, IN_DONE, OUT_WAIT, OUT_DONE.
REQ-020 IDLE: inctrl=1 -> IN_WAIT; else outctrl=1 -> OUT_WAIT with out_word <= rs_data; inctrl and outctrl both 1 -> inctrl wins, outctrl ignored.
REQ-021 IN_WAIT: in_req=1; on in_valid=1 capture rd_data <= zero-extended in_data (IN_WIDTH to 32), go IN_DONE.
REQ-022 IN_DONE: rd_we=1 and io_done=1 for exactly one cycle, in_req=0, next state IDLE.
REQ-023 OUT_WAIT: out_valid=1, out_word held stable regardless of rs_data changes; on out_ack=1 go OUT_DONE.
REQ-024 OUT_DONE: out_valid=0, io_done=1 for exactly one cycle, next state IDLE.
REQ-025 io_busy SHALL be 1 in every state except IDLE.
REQ-026 Latency: request sampled in IDLE at edge N, device already ready -> capture at N+1, io_done high during cycle after N+1 (3 cycles request-to-done).
REQ-027 Back-to-back: IDLE SHALL accept a new level request the cycle after DONE (next instruction presented after PC release); no request edge required.
REQ-028 in_valid or out_ack while not in the matching WAIT state SHALL be ignored.
REQ-029 Request deasserting while in a WAIT state SHALL NOT abort the transfer.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, including mid-transfer; all outputs 0, out_word and rd_data 0, io_err 0.
REQ-031 First transition after rst_n release SHALL occur no earlier than the first rising clk edge with rst_n=1.

Configuration
REQ-032 Macro IO_TIMEOUT_EN defined: a counter runs in IN_WAIT/OUT_WAIT; at TIMEOUT_CYCLES wait cycles without handshake the FSM SHALL go to the matching DONE state (IN_DONE writes rd_data=0), set io_err sticky until reset.
REQ-033 Macro IO_TIMEOUT_EN undefined: WAIT states SHALL wait indefinitely, no counter logic, io_err tied 0.

Structure
REQ-034 Shared package zaf_io_pkg SHALL hold the FSM state typedef, the 32-bit data-width constant and default TIMEOUT_CYCLES.
REQ-035 Timeout counter SHALL be sub-module io_timeout_counter (clear, enable, expired), instantiated only under IO_TIMEOUT_EN.

Verification
REQ-036 inctrl=1, in_valid=1, in_data=16'hBEEF -> rd_data=32'h0000BEEF, rd_we and io_done single-cycle pulse 3 cycles after request.
REQ-037 outctrl=1, rs_data=32'hDEADBEEF, out_ack held 0 for 10 cycles, rs_data changed to 0 -> out_word stays 32'hDEADBEEF, out_valid high until out_ack=1, then io_done one pulse.
REQ-038 inctrl=outctrl=1 -> input transfer only, out_valid never asserts.
REQ-039 rst_n dropped during OUT_WAIT -> outputs 0 asynchronously, IDLE after release, no io_done.
REQ-040 IO_TIMEOUT_EN, TIMEOUT_CYCLES=8, inctrl=1, in_valid=0 -> IN_DONE after 8 wait cycles, rd_data=0, io_err=1 and remains 1.
REQ-041 Two consecutive in instructions (inctrl held high across io_done) -> two separate transfers, two io_done pulses.

Source files
------------

// File: rtl/zaf_io_pkg.sv
// rtl/zaf_io_pkg.sv - shared types and constants for the io_controller slice
package zaf_io_pkg;

  localparam int DATA_W          = 32;
  localparam int TIMEOUT_DEFAULT = 1024;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    IN_WAIT  = 3'd1,
    IN_DONE  = 3'd2,
    OUT_WAIT = 3'd3,
    OUT_DONE = 3'd4
  } io_state_t;

endpackage

// File: rtl/io_timeout_counter.sv
// rtl/io_timeout_counter.sv - wait-cycle counter, expires on the CYCLES-th enabled cycle
module io_timeout_counter
  import zaf_io_pkg::*;
#(
  parameter int CYCLES = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The first enabled cycle sees cnt == 0, so the CYCLES-th one sees CYCLES-1.
  assign expired = enable && (cnt == CW'(CYCLES - 1));

endmodule

// File: rtl/io_controller.sv
// rtl/io_controller.sv - in/out instruction handshake FSM; IO_TIMEOUT_EN adds a wait-state timeout
module io_controller
  import zaf_io_pkg::*;
#(
  parameter int IN_WIDTH       = 16,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inctrl,
  input  logic                outctrl,
  input  logic [DATA_W-1:0]   rs_data,
  input  logic                in_valid,
  input  logic [IN_WIDTH-1:0] in_data,
  output logic                in_req,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_word,
  input  logic                out_ack,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_we,
  output logic                io_done,
  output logic                io_busy,
  output logic                io_err
);

  io_state_t state, state_nxt;
  logic      tmo_expired;

  if (TIMEOUT_CYCLES < 1 || IN_WIDTH < 1 || IN_WIDTH > DATA_W) begin : g_bad_cfg
    $error("io_controller: TIMEOUT_CYCLES must be >= 1 and IN_WIDTH within 1..32");
  end

`ifdef IO_TIMEOUT_EN
  logic waiting;

  assign waiting = (state == IN_WAIT) || (state == OUT_WAIT);

  io_timeout_counter #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!waiting),
    .enable (waiting),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_err <= 1'b0;
    end else if (tmo_expired) begin
      io_err <= 1'b1;
    end
  end
`else
  assign tmo_expired = 1'b0;
  assign io_err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A handshake in the same cycle as expiry wins, so real data is never dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (inctrl) begin
          state_nxt = IN_WAIT;
        end else if (outctrl) begin
          state_nxt = OUT_WAIT;
        end
      end
      IN_WAIT: begin
        if (in_valid || tmo_expired) begin
          state_nxt = IN_DONE;
        end
      end
      IN_DONE:  state_nxt = IDLE;
      OUT_WAIT: begin
        if (out_ack || tmo_expired) begin
          state_nxt = OUT_DONE;
        end
      end
      OUT_DONE: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_req    = (state == IN_WAIT);
    out_valid = (state == OUT_WAIT);
    rd_we     = (state == IN_DONE);
    io_done   = (state == IN_DONE) || (state == OUT_DONE);
    io_busy   = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_word <= '0;
      rd_data  <= '0;
    end else begin
      if (state == IDLE && !inctrl && outctrl) begin
        out_word <= rs_data;
      end
      if (state == IN_WAIT) begin
        if (in_valid) begin
          rd_data <= DATA_W'(in_data);
        end else if (tmo_expired) begin
          rd_data <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_io_controller.sv
// tb/tb_io_controller.sv - directed self-checking bench for io_controller (IO_TIMEOUT_EN aware)
module tb_io_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inctrl, outctrl;
  logic [31:0] rs_data;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_req, out_valid;
  logic [31:0] out_word;
  logic        out_ack;
  logic [31:0] rd_data;
  logic        rd_we, io_done, io_busy, io_err;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int base;
  logic ov_seen;

  always #5 clk = ~clk;

  io_controller #(
    .IN_WIDTH      (16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inctrl   (inctrl),
    .outctrl  (outctrl),
    .rs_data  (rs_data),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_req   (in_req),
    .out_valid(out_valid),
    .out_word (out_word),
    .out_ack  (out_ack),
    .rd_data  (rd_data),
    .rd_we    (rd_we),
    .io_done  (io_done),
    .io_busy  (io_busy),
    .io_err   (io_err)
  );

  always @(posedge clk) if (io_done) done_cnt++;
  always @(negedge clk) if (out_valid) ov_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; inctrl = 0; outctrl = 0; rs_data = '0;
    in_valid = 0; in_data = '0; out_ack = 0;
    tick(2);
    check("rst_in_req",   in_req,    0);
    check("rst_out_valid", out_valid, 0);
    check("rst_rd_we",    rd_we,     0);
    check("rst_io_done",  io_done,   0);
    check("rst_io_busy",  io_busy,   0);
    check("rst_io_err",   io_err,    0);
    check("rst_out_word", out_word,  0);
    check("rst_rd_data",  rd_data,   0);
    rst_n = 1'b1;
    tick(1);
    check("post_rst_idle", io_busy, 0);

    // Input with device already ready: done pulse two edges after the request edge.
    in_data = 16'hBEEF; in_valid = 1; inctrl = 1;
    tick(1);
    check("in_req_wait", in_req, 1);
    check("in_busy", io_busy, 1);
    check("in_no_done_early", io_done, 0);
    inctrl = 0;
    tick(1);
    check("in_rd_data", rd_data, 32'h0000BEEF);
    check("in_rd_we", rd_we, 1);
    check("in_io_done", io_done, 1);
    check("in_req_done", in_req, 0);
    in_valid = 0;
    tick(1);
    check("in_done_pulse_end", io_done, 0);
    check("in_we_pulse_end", rd_we, 0);
    check("in_idle", io_busy, 0);

    // Stray handshakes in IDLE do nothing.
    in_valid = 1; out_ack = 1;
    tick(2);
    check("stray_idle", io_busy, 0);
    check("stray_rd_data", rd_data, 32'h0000BEEF);
    in_valid = 0; out_ack = 0;

    // Output held across a slow acknowledge and a changing rs_data.
    rs_data = 32'hDEADBEEF; outctrl = 1;
    tick(1);
    check("out_valid", out_valid, 1);
    check("out_word", out_word, 32'hDEADBEEF);
    outctrl = 0; rs_data = '0;
    tick(10);
    check("out_valid_held", out_valid, 1);
    check("out_word_held", out_word, 32'hDEADBEEF);
    check("out_no_done", io_done, 0);
    out_ack = 1;
    tick(1);
    check("out_valid_drop", out_valid, 0);
    check("out_io_done", io_done, 1);
    check("out_no_we", rd_we, 0);
    out_ack = 0;
    tick(1);
    check("out_done_pulse_end", io_done, 0);
    check("out_idle", io_busy, 0);

    // Request dropped during IN_WAIT still completes.
    inctrl = 1;
    tick(1);
    inctrl = 0;
    tick(3);
    check("in_wait_no_abort", in_req, 1);
    in_data = 16'h0012; in_valid = 1;
    tick(1);
    check("late_rd_data", rd_data, 32'h00000012);
    check("late_io_done", io_done, 1);
    in_valid = 0;
    tick(1);

    // Simultaneous requests: input wins, output never presented.
    ov_seen = 1'b0;
    inctrl = 1; outctrl = 1; rs_data = 32'h12345678; in_data = 16'hA5A5; in_valid = 1;
    tick(1);
    check("both_in_req", in_req, 1);
    inctrl = 0; outctrl = 0;
    tick(1);
    check("both_rd_data", rd_data, 32'h0000A5A5);
    in_valid = 0;
    tick(2);
    check("both_no_out_valid", ov_seen, 0);
    check("both_out_word_kept", out_word, 32'hDEADBEEF);

    // Level request held across io_done yields two transfers.
    base = done_cnt;
    inctrl = 1; in_valid = 1; in_data = 16'h1111;
    tick(4);
    check("b2b_second_wait", in_req, 1);
    inctrl = 0;
    tick(2);
    check("b2b_done_count", done_cnt - base, 2);
    check("b2b_idle", io_busy, 0);
    in_valid = 0;

    // Asynchronous reset in OUT_WAIT.
    rs_data = 32'hCAFEF00D; outctrl = 1;
    tick(1);
    check("rst_mid_out_valid", out_valid, 1);
    outctrl = 0;
    base = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", io_busy, 0);
    check("arst_out_word", out_word, 0);
    check("arst_rd_data", rd_data, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("arst_idle", io_busy, 0);
    check("arst_no_done", done_cnt - base, 0);

`ifdef IO_TIMEOUT_EN
    // Input never arrives: expiry after 8 wait cycles, rd_data zeroed, sticky error.
    in_data = 16'h7777; in_valid = 0;
    inctrl = 1;
    tick(1);
    inctrl = 0;
    tick(7);
    check("tmo_still_waiting", in_req, 1);
    check("tmo_err_before", io_err, 0);
    tick(1);
    check("tmo_io_done", io_done, 1);
    check("tmo_rd_we", rd_we, 1);
    check("tmo_rd_data", rd_data, 0);
    check("tmo_io_err", io_err, 1);
    tick(3);
    check("tmo_err_sticky", io_err, 1);
    check("tmo_idle", io_busy, 0);
`else
    inctrl = 1; in_valid = 0;
    tick(1);
    inctrl = 0;
    tick(40);
    check("no_tmo_waits", in_req, 1);
    check("no_tmo_err", io_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
